// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: request mode encodings and the
// internal width used for wrap-aware target arithmetic.
package branch_pkg;

  typedef enum logic [1:0] {
    MODE_REL  = 2'b00,
    MODE_CALL = 2'b01,
    MODE_RET  = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  // Holds a 16-bit PC plus or minus a 15-bit offset with room for a sign bit,
  // so any wrap shows up as nonzero bits above the PC field.
  localparam int EXT_W = 18;

  // True when a widened PC +/- offset sum has left the range [0, 2^pc_w - 1].
  function automatic logic wraps(input logic [EXT_W-1:0] sum, input int pc_w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i >= pc_w && sum[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry, a pop of an empty stack is ignored. Storage is not reset.
module branch_ras
  import branch_pkg::*;
#(
  parameter int W         = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;          // next free slot; sp-1 is the top entry
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (push) begin
      if (count != CNT_W'(RAS_DEPTH)) count_next = count + CNT_W'(1);
    end else if (pop && count != '0) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Because the stack is a power-of-two ring, writing at sp when full lands
  // exactly on the oldest entry, so the wrap-around overwrite needs no extra logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push) begin
        sp <= sp + PTR_W'(1);
      end else if (pop && count != '0) begin
        sp <= sp - PTR_W'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(RAS_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[sp] <= push_data;
  end

  assign top = mem[sp - PTR_W'(1)];

endmodule

// File: rtl/branch_unit.sv
// Branch target unit: relative/call/return/absolute targets with a return
// address stack and one registered output stage. Define BRANCH_UNIT_OVF_EN
// to enable target-wrap detection on ovf; otherwise ovf is tied low.
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 6,
  parameter int SIGN_MAG  = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] pc_in,
  input  logic [15:0]     const_in,
  input  logic [1:0]      mode,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] branch,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ovf
);

  mode_e            req_mode;
  logic             accept;
  logic             push;
  logic             pop;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  target;
  logic [EXT_W-1:0] mag_ext;
  logic [EXT_W-1:0] off_ext;
  logic [EXT_W-1:0] rel_ext;
  logic             unused_bits;

  // Handshake: a request transfers when in_valid && in_ready; a result transfers
  // when out_valid && out_ready. in_ready may depend on out_ready combinationally,
  // which lets the single output register refill in the cycle it drains.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign req_mode = mode_e'(mode);
  assign push     = accept && (req_mode == MODE_CALL);
  assign pop      = accept && (req_mode == MODE_RET) && !ras_empty;
  assign pc_inc   = pc_in + PC_W'(1);

  always_comb begin
    mag_ext = EXT_W'(const_in[OFF_W-1:0]);
    if (SIGN_MAG != 0) begin
      off_ext = const_in[OFF_W] ? (EXT_W'(0) - mag_ext) : mag_ext;
    end else begin
      off_ext = {{(EXT_W-OFF_W-1){const_in[OFF_W]}}, const_in[OFF_W:0]};
    end
  end

  assign rel_ext = EXT_W'(pc_in) + off_ext;

  always_comb begin
    target = rel_ext[PC_W-1:0];
    case (req_mode)
      MODE_REL, MODE_CALL: target = rel_ext[PC_W-1:0];
      MODE_RET:            target = ras_empty ? pc_inc : ras_top;
      MODE_ABS:            target = const_in[PC_W-1:0];
      default:             target = rel_ext[PC_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      branch    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      branch    <= target;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_UNIT_OVF_EN
  logic target_ovf;

  always_comb begin
    target_ovf = 1'b0;
    case (req_mode)
      MODE_REL, MODE_CALL: target_ovf = wraps(rel_ext, PC_W);
      MODE_RET:            target_ovf = ras_empty;
      default:             target_ovf = 1'b0;
    endcase
  end

  // ovf travels with branch, so it only changes when a new result is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= target_ovf;
    end
  end

  assign unused_bits = ^const_in;
`else
  assign ovf         = 1'b0;
  assign unused_bits = ^{const_in, rel_ext};
`endif

  branch_ras #(
    .W        (PC_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in bits (legal range 4..16).
REQ-002 SHALL have parameter OFF_W, default 6, offset magnitude width taken from const_in[OFF_W-1:0] (OFF_W < 16).
REQ-003 SHALL have parameter SIGN_MAG, default 1: 1 = sign-magnitude offset, sign at const_in[OFF_W]; 0 = two's-complement offset in const_in[OFF_W:0].
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-009 pc_in  input  PC_W  current program counter.
REQ-010 const_in  input  16  immediate field from the instruction decoder.
REQ-011 mode  input  2  00 relative, 01 call, 10 return, 11 absolute.
REQ-012 flush  input  1  discard the pending result and block acceptance this cycle.
REQ-013 out_valid  output  1  branch holds a valid target.
REQ-014 out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
REQ-015 branch  output  PC_W  computed target.
REQ-016 ras_empty, ras_full  output  1 each  return-address-stack status.
REQ-017 ovf  output  1  target wrapped modulo 2^PC_W.

Function
REQ-018 SHALL register each result, so latency is exactly 1 cycle from acceptance to out_valid.
REQ-019 SHALL drive in_ready = !flush && (!out_valid || out_ready), which gives single-stage skid-free throughput of 1 request/cycle.
REQ-020 Relative mode SHALL produce branch = pc_in + off (sign 0) or pc_in - off (sign 1), where off is the zero-extended magnitude; the result is taken modulo 2^PC_W.
REQ-021 With SIGN_MAG=0, the offset SHALL be sign-extended from bit OFF_W before the add, also modulo 2^PC_W.
REQ-022 Call mode SHALL compute the target as in relative mode and push pc_in+1 (mod 2^PC_W) onto the RAS.
REQ-023 A call with the RAS full SHALL overwrite the oldest entry (circular), and ras_full SHALL stay 1.
REQ-024 Return mode SHALL produce branch = top of the RAS and pop it.
REQ-025 A return with the RAS empty SHALL produce branch = pc_in+1, leave the RAS unchanged and assert ovf for that result.
REQ-026 Absolute mode SHALL produce branch = const_in[PC_W-1:0].
REQ-027 The RAS SHALL change only on an accepted request; flush never alters the RAS.
REQ-028 flush SHALL clear out_valid on the next edge, and a request presented in the same cycle SHALL NOT be accepted.
REQ-029 While out_valid=1 and out_ready=0, branch and ovf SHALL hold stable.
REQ-030 ras_empty and ras_full SHALL be registered and reflect the post-update occupancy.

Reset
REQ-031 On a rising clk edge with rst_n=0, the block SHALL force out_valid=0, branch=0, ovf=0, RAS occupancy=0, ras_empty=1 and ras_full=0, regardless of flush or in-flight requests.
REQ-032 RAS storage contents SHALL need no reset; only pointers and count are reset.

Configuration
REQ-033 Macro BRANCH_UNIT_OVF_EN defined: ovf SHALL be 1 when a relative or call target wraps past 0 or 2^PC_W-1, or on an empty-RAS return.
REQ-034 Macro BRANCH_UNIT_OVF_EN undefined: the ovf port SHALL remain and be tied to 0, and no detection logic SHALL be generated.

Structure
REQ-035 Mode encodings (MODE_REL, MODE_CALL, MODE_RET, MODE_ABS) SHALL live in shared package branch_pkg.
REQ-036 The RAS SHALL be a sub-module named branch_ras (push, pop, top, empty, full, parameter RAS_DEPTH).

Verification (PC_W=10, OFF_W=6, SIGN_MAG=1, RAS_DEPTH=4)
REQ-037 Forward relative: pc_in=100, const_in=0x0005, mode=00 -> branch=105 and out_valid=1 one cycle later.
REQ-038 Backward relative: pc_in=100, const_in=0x0045 -> branch=95; wrap case pc_in=1020, const_in=0x000A -> branch=6 and ovf=1 (macro defined) or ovf=0 (macro undefined).
REQ-039 RAS sequence:
- calls at pc 10, 20, 30, 40, 50 -> ras_full=1;
- four returns -> branch 51, 41, 31, 21, then ras_empty=1;
- fifth return at pc_in=7 -> branch=8 with ovf=1.
REQ-040 Backpressure: out_ready=0 for 3 cycles -> in_ready=0 and branch held; releasing out_ready -> next request accepted in the same cycle.
REQ-041 Flush and reset: flush with in_valid=1 -> no acceptance and out_valid=0 next cycle; rst_n=0 mid-stream with 2 RAS entries -> out_valid=0, ras_empty=1 after the edge.
